// File: rtl/serial_byte_assembler_pkg.sv
// Shared types and helpers for the serial byte assembler.
//   sba_state_t : assembler state (ACC = accumulating bits,
//                 STALL = word complete but the output register is occupied)
//   cnt_w()     : width of the bit counter for a given word width, sized so it
//                 can hold the value DATA_W that marks a completed, stalled word
package serial_byte_assembler_pkg;

  typedef enum logic {
    ACC   = 1'b0,
    STALL = 1'b1
  } sba_state_t;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_byte_assembler.sv
// Serial-to-parallel stage: collects DATA_W serial bits into one word and
// presents it on a single-entry valid/ready output register.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds data stable while
// valid is high and ready is low; ready never depends combinationally on the
// partner's valid. Here ser_ready depends only on registered state and on
// clear, and never on byte_ready.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   ser_valid   in   1       serial bit offered
//   ser_bit     in   1       serial data bit
//   ser_ready   out  1       stage accepts a bit this cycle
//   clear       in   1       synchronous abort of the partially assembled word
//   byte_valid  out  1       output word valid
//   byte_data   out  DATA_W  assembled word
//   byte_lsb    out  1       byte_data[0]
//   byte_ready  in   1       consumer takes the word
//   drop_pulse  out  1       one-cycle pulse: clear discarded at least one bit
//   dbg_state   out  state   current assembler state, for observation
//
// Parameters
//   DATA_W      word width in bits (>= 2)
//   LSB_FIRST   1: first accepted bit lands in bit 0; 0: in bit DATA_W-1
module serial_byte_assembler
  import serial_byte_assembler_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_valid,
  input  logic              ser_bit,
  output logic              ser_ready,
  input  logic              clear,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_lsb,
  input  logic              byte_ready,
  output logic              drop_pulse,
  output sba_state_t        dbg_state
);

  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);

  sba_state_t        state_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic              bit_accept;
  logic              word_take;

  // Refuse bits while stalled, and during the clear cycle so that a bit
  // offered alongside clear is not silently swallowed.
  assign ser_ready  = (state_q == ACC) && !clear;
  assign bit_accept = ser_valid && ser_ready;
  assign word_take  = byte_valid && byte_ready;
  assign byte_lsb   = byte_data[0];
  assign dbg_state  = state_q;

  // LSB-first: shift right, new bit enters at the top, so after DATA_W shifts
  // the first bit has walked down to bit 0. MSB-first is the mirror image.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shift_next = {ser_bit, shift_q[DATA_W-1:1]};
    end else begin : g_msb_first
      assign shift_next = {shift_q[DATA_W-2:0], ser_bit};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      count_q    <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;

      // Default for the output register: a take drains it. Any reload below
      // overrides this, keeping byte_valid high across back-to-back words.
      if (word_take) begin
        byte_valid <= 1'b0;
      end

      if (clear) begin
        // Abort the partial (or stalled) word; the output register keeps
        // whatever it already holds.
        drop_pulse <= (count_q != '0);
        count_q    <= '0;
        shift_q    <= '0;
        state_q    <= ACC;
      end else begin
        case (state_q)
          ACC: begin
            if (bit_accept) begin
              if (count_q == LAST_IDX) begin
                if (!byte_valid || word_take) begin
                  // Output slot free this cycle: hand the word over directly.
                  byte_data  <= shift_next;
                  byte_valid <= 1'b1;
                  count_q    <= '0;
                  shift_q    <= '0;
                end else begin
                  // Output occupied: park the completed word in the shift
                  // register and stop accepting bits.
                  shift_q <= shift_next;
                  count_q <= FULL_CNT;
                  state_q <= STALL;
                end
              end else begin
                shift_q <= shift_next;
                count_q <= count_q + CW'(1);
              end
            end
          end

          STALL: begin
            if (word_take) begin
              byte_data  <= shift_q;
              byte_valid <= 1'b1;
              count_q    <= '0;
              shift_q    <= '0;
              state_q    <= ACC;
            end
          end

          default: begin
            state_q <= ACC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_assembler.sv
module tb_serial_byte_assembler;
  import serial_byte_assembler_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ser_valid;
  logic       ser_bit;
  logic       clear;
  logic       byte_ready;

  logic       ser_ready_a, byte_valid_a, byte_lsb_a, drop_pulse_a;
  logic [7:0] byte_data_a;
  sba_state_t dbg_state_a;

  logic       ser_ready_b, byte_valid_b, byte_lsb_b, drop_pulse_b;
  logic [7:0] byte_data_b;
  sba_state_t dbg_state_b;

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_byte_assembler #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .ser_ready(ser_ready_a), .clear(clear), .byte_valid(byte_valid_a),
    .byte_data(byte_data_a), .byte_lsb(byte_lsb_a), .byte_ready(byte_ready),
    .drop_pulse(drop_pulse_a), .dbg_state(dbg_state_a)
  );

  serial_byte_assembler #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .ser_ready(ser_ready_b), .clear(clear), .byte_valid(byte_valid_b),
    .byte_data(byte_data_b), .byte_lsb(byte_lsb_b), .byte_ready(byte_ready),
    .drop_pulse(drop_pulse_b), .dbg_state(dbg_state_b)
  );

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_bit   = b;
    tick();
    ser_valid = 1'b0;
  endtask

  // Serial order is w[0] first.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] stream;
    logic [7:0]  exp_w;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    clear      = 1'b0;
    byte_ready = 1'b0;

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_valid", 32'(byte_valid_a), 32'd0);
    check("rst_data", 32'(byte_data_a), 32'h00);
    check("rst_ser_ready", 32'(ser_ready_a), 32'd1);
    check("rst_drop", 32'(drop_pulse_a), 32'd0);

    // 1: reset in the middle of a run
    send_word(8'hA5);
    check("pre_rst_valid", 32'(byte_valid_a), 32'd1);
    check("pre_rst_data", 32'(byte_data_a), 32'hA5);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(byte_valid_a), 32'd0);
    check("midrst_data", 32'(byte_data_a), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ser_ready", 32'(ser_ready_a), 32'd1);
    check("midrst_drop", 32'(drop_pulse_a), 32'd0);
    byte_ready = 1'b1;
    send_word(8'h3C);
    check("after_rst_word", 32'(byte_data_a), 32'h3C);
    check("after_rst_valid", 32'(byte_valid_a), 32'd1);
    tick();
    check("after_rst_drain", 32'(byte_valid_a), 32'd0);

    // 2: all ones, latency and single-cycle valid
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("ff_not_yet", 32'(byte_valid_a), 32'd0);
    send_bit(1'b1);
    check("ff_valid", 32'(byte_valid_a), 32'd1);
    check("ff_data", 32'(byte_data_a), 32'hFF);
    check("ff_lsb", 32'(byte_lsb_a), 32'd1);
    tick();
    check("ff_one_cycle", 32'(byte_valid_a), 32'd0);

    // 3: bit order, both orientations
    send_word(8'hAA);
    check("aa_lsb_first", 32'(byte_data_a), 32'hAA);
    check("aa_lsb_pin", 32'(byte_lsb_a), 32'd0);
    check("aa_msb_first", 32'(byte_data_b), 32'h55);
    check("aa_msb_lsb_pin", 32'(byte_lsb_b), 32'd1);
    tick();

    // 4: back-pressure, stall, no bit loss
    byte_ready = 1'b0;
    send_word(8'h0F);
    check("bp_first_valid", 32'(byte_valid_a), 32'd1);
    check("bp_first_data", 32'(byte_data_a), 32'h0F);
    for (int i = 0; i < 7; i++) send_bit(i >= 4 ? 1'b1 : 1'b0);
    check("bp_hold_data", 32'(byte_data_a), 32'h0F);
    check("bp_ready_bit15", 32'(ser_ready_a), 32'd1);
    send_bit(1'b1);
    check("bp_ser_ready_low", 32'(ser_ready_a), 32'd0);
    check("bp_state_stall", 32'(dbg_state_a), 32'(STALL));
    check("bp_hold_data2", 32'(byte_data_a), 32'h0F);
    send_bit(1'b0);
    check("bp_stall_hold", 32'(byte_data_a), 32'h0F);
    byte_ready = 1'b1;
    tick();
    check("bp_second_valid", 32'(byte_valid_a), 32'd1);
    check("bp_second_data", 32'(byte_data_a), 32'hF0);
    check("bp_back_acc", 32'(ser_ready_a), 32'd1);
    tick();
    check("bp_drained", 32'(byte_valid_a), 32'd0);

    // 5: clear behaviour
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    clear = 1'b1;
    #1;
    check("clr_ser_ready", 32'(ser_ready_a), 32'd0);
    tick();
    clear = 1'b0;
    check("clr_drop", 32'(drop_pulse_a), 32'd1);
    tick();
    check("clr_drop_once", 32'(drop_pulse_a), 32'd0);
    send_word(8'h96);
    check("clr_clean_word", 32'(byte_data_a), 32'h96);
    check("clr_clean_valid", 32'(byte_valid_a), 32'd1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_empty_nodrop", 32'(drop_pulse_a), 32'd0);
    clear     = 1'b1;
    ser_valid = 1'b1;
    ser_bit   = 1'b1;
    tick();
    clear     = 1'b0;
    ser_valid = 1'b0;
    check("clr_vs_bit_nodrop", 32'(drop_pulse_a), 32'd0);
    send_word(8'h5A);
    check("clr_vs_bit_word", 32'(byte_data_a), 32'h5A);
    tick();
    // clear while stalled discards the parked word, keeps the output word
    byte_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    check("clr_stall_state", 32'(dbg_state_a), 32'(STALL));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_stall_drop", 32'(drop_pulse_a), 32'd1);
    check("clr_stall_state_acc", 32'(dbg_state_a), 32'(ACC));
    check("clr_stall_out_kept", 32'(byte_data_a), 32'h11);
    check("clr_stall_valid_kept", 32'(byte_valid_a), 32'd1);
    byte_ready = 1'b1;
    tick();
    check("clr_stall_discarded", 32'(byte_valid_a), 32'd0);

    // 6: continuous stream, one word per 8 cycles, ser_ready always high
    stream = 24'h563412;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
    for (int i = 0; i < 24; i++) begin
      check("stream_ser_ready", 32'(ser_ready_a), 32'd1);
      ser_valid = 1'b1;
      ser_bit   = stream[i];
      tick();
      check("stream_valid", 32'(byte_valid_a), (i % 8 == 7) ? 32'd1 : 32'd0);
      if (byte_valid_a && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("stream_data", 32'(byte_data_a), 32'(exp_w));
      end
    end
    ser_valid = 1'b0;
    check("stream_all_words", 32'(exp_q.size()), 32'd0);
    tick();
    check("stream_drained", 32'(byte_valid_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
